// File: rtl/imm_pkg.sv
// Shared immediate-generation types: immediate-type encoding, RV opcodes and
// the funct3 values that turn an OP-IMM into a shift.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_R     = 3'b010,
        IMM_B     = 3'b011,
        IMM_U     = 3'b100,
        IMM_J     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_ILL   = 3'b111
    } imm_type_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
// Zero latency; no flow control of its own.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0
) (
    input  logic [31:0]     i_inst,
    input  logic [2:0]      i_imm_type,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_type,
    output logic            o_illegal
);

    imm_type_e w_type;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_type = imm_type_e'(i_imm_type);
        if (AUTO_DECODE != 0) begin
            case (i_inst[6:0])
                OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: w_type = IMM_I;
                OP_IMM: w_type = (i_inst[14:12] == F3_SLLI || i_inst[14:12] == F3_SRXI)
                                 ? IMM_SHAMT : IMM_I;
                OP_STORE:         w_type = IMM_S;
                OP_REG:           w_type = IMM_R;
                OP_BRANCH:        w_type = IMM_B;
                OP_LUI, OP_AUIPC: w_type = IMM_U;
                OP_JAL:           w_type = IMM_J;
                default:          w_type = IMM_ILL;
            endcase
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_type)
            IMM_I: w_imm = XLEN'($signed(i_inst[31:20]));
            IMM_S: w_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
            IMM_B: w_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                          i_inst[11:8], 1'b0}));
            IMM_U: w_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
            IMM_J: w_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                          i_inst[30:21], 1'b0}));
            // RV64 shifts carry a 6-bit shamt, RV32 only 5
            IMM_SHAMT: w_imm = (XLEN == 64) ? XLEN'(i_inst[25:20]) : XLEN'(i_inst[24:20]);
            default: w_imm = '0;
        endcase
    end

    assign o_imm      = w_imm;
    assign o_imm_type = w_type;
    assign o_illegal  = (w_type == IMM_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry output queue; one cycle empty-to-valid.
// in_ready drops only when the queue is full, regardless of out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int AUTO_DECODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_imm_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [15:0]     illegal_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [XLEN-1:0] r_imm [DEPTH];
    logic [2:0]      r_type [DEPTH];
    logic            r_ill [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [15:0]     r_ill_cnt;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;
    logic            w_out_valid;

    imm_decode #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_decode (
        .i_inst     (in_inst),
        .i_imm_type (in_imm_type),
        .o_imm      (w_imm),
        .o_imm_type (w_type),
        .o_illegal  (w_illegal)
    );

    assign in_ready    = (r_count < DEPTH_C);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && in_ready && !flush;
    assign w_pop       = w_out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ill_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_push && w_illegal && r_ill_cnt != 16'hFFFF) r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    // Payload storage carries no reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wr_ptr]  <= w_imm;
            r_type[r_wr_ptr] <= w_type;
            r_ill[r_wr_ptr]  <= w_illegal;
        end
    end

    assign out_valid     = w_out_valid;
    assign out_imm       = w_out_valid ? r_imm[r_rd_ptr]  : '0;
    assign out_imm_type  = w_out_valid ? r_type[r_rd_ptr] : 3'b000;
    assign out_illegal   = w_out_valid && r_ill[r_rd_ptr];
    assign illegal_count = r_ill_cnt;

endmodule
